prga: RTL

- ARC4 pseudo-random generation and decryption engine; the reader/consumer of the S array that the key-scheduling block writes.
- After key scheduling has populated S, this block:
  - reads a length-prefixed ciphertext from CT memory;
  - generates the keystream while swapping S in place;
  - writes the length-prefixed plaintext to PT memory.
- Sits between S memory, CT ROM and PT RAM, under the top-level controller via an en/rdy handshake.

---
 rtl/prga_if.sv | 34 +++
 rtl/prga.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/prga_if.sv
// prga_if: bundles the start handshake and the three memory buses of the
// ARC4 PRGA engine.
//
//   en, rdy                      start request / idle indication
//   s_addr, s_wrdata, s_wren     S memory address, write data, write enable
//   s_rddata                     S memory read data (one-cycle latency)
//   ct_addr, ct_rddata           ciphertext memory address / read data
//   pt_addr, pt_wrdata, pt_wren  plaintext memory address / write data / enable
//
// The master modport is the engine, which drives the memory addresses.
// The slave modport is the environment: the controller and the memories.
interface prga_if;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    modport master (
        input  en, s_rddata, ct_rddata,
        output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

    modport slave (
        output en, s_rddata, ct_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );
endinterface

// File: rtl/prga.sv
// prga: ARC4 pseudo-random generation and decryption engine.
// Reads a length-prefixed ciphertext from CT memory, runs the ARC4 keystream
// generator over the S array already filled by key scheduling (swapping S in
// place) and writes the length-prefixed plaintext to PT memory.
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-high reset; aborts a run immediately
//   bus  prga_if.master: en/rdy handshake, S / CT / PT memory buses
//
// All memories read synchronously: address in cycle N, data in cycle N+1.
// Memory outputs are decoded from the state and internal registers only.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | rdy=1, waiting for en
// RD_LEN | present ct_addr=0
// LD_LEN | capture length byte L
// WR_LEN | write L to pt[0]; L==0 finishes immediately
// INC_I  | advance i and k
// RD_SI  | present s_addr=i
// LD_SI  | capture si, j += si
// RD_SJ  | present s_addr=j
// LD_SJ  | capture sj
// WR_SI  | s[i] <= sj
// WR_SJ  | s[j] <= si
// RD_PAD | present s_addr=si+sj and ct_addr=k
// LD_PAD | capture pad and ciphertext byte
// WR_PT  | pt[k] <= pad ^ ctb; k==L finishes
// DONE   | one cycle before returning to IDLE
module prga (
    input  logic   clk,
    input  logic   rst,
    prga_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, RD_LEN, LD_LEN, WR_LEN, INC_I, RD_SI, LD_SI, RD_SJ,
        LD_SJ, WR_SI, WR_SJ, RD_PAD, LD_PAD, WR_PT, DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] i;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] len;
    logic [7:0] si;
    logic [7:0] sj;
    logic [7:0] pad;
    logic [7:0] ctb;
    logic       ready;

    logic [7:0] s_addr;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 8'd0;
            len   <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            pad   <= 8'd0;
            ctb   <= 8'd0;
        end else begin
            state <= state_next;
            // rdy is registered: it follows the state we are about to enter
            ready <= (state_next == IDLE);
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        i <= 8'd0;
                        j <= 8'd0;
                        k <= 8'd0;
                    end
                end
                LD_LEN: len <= bus.ct_rddata;
                INC_I: begin
                    i <= i + 8'd1;
                    k <= k + 8'd1;
                end
                LD_SI: begin
                    si <= bus.s_rddata;
                    j  <= j + bus.s_rddata;
                end
                LD_SJ: sj <= bus.s_rddata;
                LD_PAD: begin
                    pad <= bus.s_rddata;
                    ctb <= bus.ct_rddata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        s_addr     = 8'd0;
        s_wrdata   = 8'd0;
        s_wren     = 1'b0;
        ct_addr    = 8'd0;
        pt_addr    = 8'd0;
        pt_wrdata  = 8'd0;
        pt_wren    = 1'b0;
        case (state)
            IDLE:   if (bus.en) state_next = RD_LEN;
            RD_LEN: state_next = LD_LEN;
            LD_LEN: state_next = WR_LEN;
            WR_LEN: begin
                pt_wrdata  = len;
                pt_wren    = 1'b1;
                state_next = (len == 8'd0) ? DONE : INC_I;
            end
            INC_I:  state_next = RD_SI;
            RD_SI: begin
                s_addr     = i;
                state_next = LD_SI;
            end
            LD_SI:  state_next = RD_SJ;
            RD_SJ: begin
                s_addr     = j;
                state_next = LD_SJ;
            end
            LD_SJ:  state_next = WR_SI;
            // when i==j both writes carry the same value, so S is unchanged
            WR_SI: begin
                s_addr     = i;
                s_wrdata   = sj;
                s_wren     = 1'b1;
                state_next = WR_SJ;
            end
            WR_SJ: begin
                s_addr     = j;
                s_wrdata   = si;
                s_wren     = 1'b1;
                state_next = RD_PAD;
            end
            RD_PAD: begin
                s_addr     = si + sj;
                ct_addr    = k;
                state_next = LD_PAD;
            end
            LD_PAD: state_next = WR_PT;
            WR_PT: begin
                pt_addr    = k;
                pt_wrdata  = pad ^ ctb;
                pt_wren    = 1'b1;
                state_next = (k == len) ? DONE : INC_I;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.rdy       = ready;
    assign bus.s_addr    = s_addr;
    assign bus.s_wrdata  = s_wrdata;
    assign bus.s_wren    = s_wren;
    assign bus.ct_addr   = ct_addr;
    assign bus.pt_addr   = pt_addr;
    assign bus.pt_wrdata = pt_wrdata;
    assign bus.pt_wren   = pt_wren;

endmodule
